// File: rtl/edge_event_ctrl_pkg.sv
// Shared definitions for the edge event controller: register word offsets,
// bus handshake states and the byte-strobe mask helper.
package edge_event_ctrl_pkg;

    localparam logic [2:0] LEVEL_OFS   = 3'd0;
    localparam logic [2:0] RISE_EN_OFS = 3'd1;
    localparam logic [2:0] FALL_EN_OFS = 3'd2;
    localparam logic [2:0] PENDING_OFS = 3'd3;
    localparam logic [2:0] IRQ_EN_OFS  = 3'd4;
    localparam logic [2:0] COUNT_OFS   = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_t;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/edge_event_ctrl_finder.sv
// Per-input synchronizer and dual edge detector; one shared 4-flop chain
// feeds both the rise and fall pulses so nothing is synchronized twice.
module dual_edge_finder (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_in,
    output logic level,
    output logic rise,
    output logic fall
);

    // sync[0] is s1 (first capture), sync[3] is s4
    logic [3:0] sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[2:0], sig_in};
            rise <= sync[2] & ~sync[3];
            fall <= ~sync[2] & sync[3];
        end
    end

    assign level = sync[2];

endmodule

// File: rtl/edge_event_ctrl.sv
// Memory-mapped edge event controller: sticky pending bits, saturating event
// counter and a registered level interrupt behind a one-shot bus handshake.
module edge_event_ctrl
    import edge_event_ctrl_pkg::*;
#(
    parameter int NUM_IN = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_IN-1:0] sig_in,
    input  logic              sel,
    input  logic [2:0]        addr,
    input  logic [3:0]        wstrb,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              irq
);

    logic [NUM_IN-1:0] level;
    logic [NUM_IN-1:0] rise;
    logic [NUM_IN-1:0] fall;
    logic [NUM_IN-1:0] ev;

    logic [NUM_IN-1:0] rise_en;
    logic [NUM_IN-1:0] fall_en;
    logic [NUM_IN-1:0] pending;
    logic [NUM_IN-1:0] irq_en;
    logic [CNT_W-1:0]  count;

    bus_state_t state;
    bus_state_t state_next;
    logic       access;
    logic       wr_en;
    logic       rd_en;

    logic [31:0]       byte_mask;
    logic [NUM_IN-1:0] bmask;
    logic [NUM_IN-1:0] wbits;
    logic [NUM_IN-1:0] w1c;
    logic              count_wr;
    logic [31:0]       rd_val;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_edge
        dual_edge_finder u_finder (
            .clk     (clk),
            .reset_n (reset_n),
            .sig_in  (sig_in[i]),
            .level   (level[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

    if (NUM_IN < 32) begin : g_unused
        logic unused_hi;
        assign unused_hi = ^{wdata[31:NUM_IN], byte_mask[31:NUM_IN]};
    end

    assign ev = (rise & rise_en) | (fall & fall_en);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Only the IDLE->ACK transition performs an access, so a held sel acts once.
    always_comb begin
        state_next = state;
        access     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sel) begin
                    access     = 1'b1;
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!sel) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign wr_en     = access & (|wstrb);
    assign rd_en     = access & ~(|wstrb);
    assign byte_mask = strb_mask(wstrb);
    assign bmask     = byte_mask[NUM_IN-1:0];
    assign wbits     = wdata[NUM_IN-1:0] & bmask;
    assign w1c       = (wr_en && addr == PENDING_OFS) ? wbits : '0;
    assign count_wr  = wr_en && addr == COUNT_OFS;

    always_comb begin
        rd_val = '0;
        case (addr)
            LEVEL_OFS:   rd_val[NUM_IN-1:0] = level;
            RISE_EN_OFS: rd_val[NUM_IN-1:0] = rise_en;
            FALL_EN_OFS: rd_val[NUM_IN-1:0] = fall_en;
            PENDING_OFS: rd_val[NUM_IN-1:0] = pending;
            IRQ_EN_OFS:  rd_val[NUM_IN-1:0] = irq_en;
            COUNT_OFS:   rd_val[CNT_W-1:0]  = count;
            default:     rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en <= '0;
            fall_en <= '0;
            irq_en  <= '0;
        end else if (wr_en) begin
            if (addr == RISE_EN_OFS) rise_en <= (rise_en & ~bmask) | wbits;
            if (addr == FALL_EN_OFS) fall_en <= (fall_en & ~bmask) | wbits;
            if (addr == IRQ_EN_OFS)  irq_en  <= (irq_en & ~bmask) | wbits;
        end
    end

    // A new event on the same cycle as its W1C clear keeps the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
            irq     <= 1'b0;
        end else begin
            pending <= (pending & ~w1c) | ev;
            irq     <= |(pending & irq_en);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (count_wr) begin
            count <= (|ev) ? CNT_W'(1) : '0;
        end else if ((|ev) && count != {CNT_W{1'b1}}) begin
            count <= count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= access;
            if (rd_en) rdata <= rd_val;
        end
    end

endmodule

// File: doc/edge_event_ctrl.md
Name: edge_event_ctrl

Overview:
- Memory-mapped event controller for up to 32 asynchronous inputs (buttons, GPIO pins).
- Each input passes through a per-input synchronizer and edge detector.
- Qualified rising and/or falling edges set sticky pending bits, increment a saturating event counter, and drive a registered interrupt to the picorv32 core.
- Sits on the native CPU bus beside the other peripherals; software configures, polls and acknowledges events.

Parameters:
- NUM_IN, 8, number of monitored inputs; legal range 1..32.
- CNT_W, 16, event counter width; legal range 1..32.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- sig_in  in  NUM_IN  asynchronous inputs
- sel  in  1  bus select for this block
- addr  in  3  word offset (byte address bits [4:2])
- wstrb  in  4  byte write strobes; 0 means read
- wdata  in  32  write data
- rdata  out  32  read data
- ready  out  1  transfer-complete pulse
- irq  out  1  level interrupt request

Behaviour:
- Reset values: rdata=0, ready=0, irq=0. All sync stages, RISE_EN, FALL_EN, PENDING, IRQ_EN and COUNT are 0.
- Edge detection, per input:
  - Four-flop chain s1..s4 samples sig_in.
  - rise = s4==0 && s3==1; fall = s4==1 && s3==0.
  - Both rise and fall are registered one-cycle pulses.
  - A pin change captured into s1 at edge k produces a pulse during cycle k+3.
- Qualified event: ev[i] = (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- PENDING update: PENDING[i] <= (PENDING[i] & ~w1c[i]) | ev[i].
  - PENDING is set on the edge after ev.
  - If an event and a W1C clear hit the same bit in the same cycle, the event wins and the bit stays 1.
- COUNT:
  - Increments by 1 on any cycle where |ev is true, regardless of how many bits fire.
  - Saturates at all-ones; no wrap.
  - A write to COUNT loads 0, or 1 if |ev is true in that same cycle.
- irq <= |(PENDING & IRQ_EN), registered: one cycle after PENDING updates.
- Register map (byte offsets):
  - 0x00 LEVEL, RO: s3 synchronized levels.
  - 0x04 RISE_EN, RW.
  - 0x08 FALL_EN, RW.
  - 0x0C PENDING, RO; writing 1 clears the bit.
  - 0x10 IRQ_EN, RW.
  - 0x14 COUNT, RO; any write clears it.
  - 0x18 and 0x1C: read 0, writes ignored.
  - Bits at and above NUM_IN read 0 and ignore writes.
- Write strobes are honoured per byte for RW and W1C registers.
- Bus handshake:
  - Two-state FSM, IDLE and ACK.
  - IDLE: when sel=1, perform the access, latch rdata (reads) and move to ACK with ready=1 for exactly one cycle.
  - ACK: ready=0; return to IDLE only once sel=0. This prevents a held sel from producing a double access.
  - Write side effects take effect at the same edge that raises ready.
  - rdata holds its value until the next read.
- Reset asserted mid-transfer: everything returns to reset values asynchronously. A pending ready is dropped and the CPU retries.
- Synchronizer reset value is 0. An input that is high at reset release therefore produces one rise event about 3 cycles later; RISE_EN is 0 at that point, so the event is masked.

Decomposition:
- Shared package: register offset constants (LEVEL_OFS, RISE_EN_OFS, FALL_EN_OFS, PENDING_OFS, IRQ_EN_OFS, COUNT_OFS) and FSM state encodings.
- One sub-module: dual_edge_finder (clk, reset_n, sig_in, rise, fall).
  - It uses one shared 4-stage chain and produces both pulses, so the controller does not instantiate separate rising and falling finders that would duplicate synchronizers.
  - Instantiated NUM_IN times with a generate loop.

Test Plan:
- Reset then read every register -> all read 0x00000000; ready pulses high for exactly 1 cycle per access; irq=0.
- RISE_EN=0x01, IRQ_EN=0x01, sig_in[0] driven 0->1 -> PENDING=0x01 and COUNT=1 within 5 cycles, irq=1 one cycle later; writing PENDING=0x01 drops irq.
- FALL_EN=0x80, toggle sig_in[7] 1->0 then 0->1 -> PENDING=0x80, COUNT=1 (rise not enabled); LEVEL bit 7 tracks the pin.
- W1C to PENDING bit 2 in the same cycle a new qualified edge on input 2 fires -> PENDING bit 2 remains 1 and COUNT increments.
- 70000 enabled edges with CNT_W=16 -> COUNT saturates at 0xFFFF; a write to COUNT -> reads 0.
- Hold sel=1 across 5 cycles on a PENDING write -> a single ready pulse and a single side effect; reset_n asserted during ACK -> ready=0 immediately and all registers reset.
